// File: rtl/stage4_n_type_scheduler.sv
// stage4_n_type_scheduler
// Steps through a programmable table of per-lane N-type control codes
// (lanes m1/m2/m3) under a valid/ready handshake, repeating the table for a
// programmed number of decoding iterations. The three control outputs drive
// the stage-4 N-type message selector directly. When no row is being
// presented the controls carry IDLE_CODE, which keeps the selector on its
// default message.
//
// Ports
//   i_clk, i_rst_n        : clock (rising edge), synchronous active-low reset
//   i_cfg_we/addr/data    : schedule row write, data = {m3,m2,m1}
//   i_start               : begin a run, samples i_num_rows / i_num_iter
//   i_num_rows            : rows per iteration, 0..DEPTH
//   i_num_iter            : iteration count, 0 behaves as 1
//   i_abort               : terminate the run without a done pulse
//   i_out_ready           : downstream accepts the presented row
//   o_N_type_control_m*   : lane control codes
//   o_out_valid           : controls hold a scheduled row
//   o_busy                : run in progress (RUN or DONE)
//   o_done                : one-cycle completion pulse
//   o_cfg_err             : sticky illegal-code / illegal-write flag
module stage4_n_type_scheduler #(
   parameter int                CTRL_W    = 3,
   parameter int                DEPTH     = 16,
   parameter int                ADDR_W    = 4,
   parameter int                ITER_W    = 5,
   parameter logic [CTRL_W-1:0] IDLE_CODE = 3'b111
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_cfg_we,
   input  logic [ADDR_W-1:0]     i_cfg_addr,
   input  logic [3*CTRL_W-1:0]   i_cfg_data,
   input  logic                  i_start,
   input  logic [ADDR_W:0]       i_num_rows,
   input  logic [ITER_W-1:0]     i_num_iter,
   input  logic                  i_abort,
   input  logic                  i_out_ready,
   output logic [CTRL_W-1:0]     o_N_type_control_m1,
   output logic [CTRL_W-1:0]     o_N_type_control_m2,
   output logic [CTRL_W-1:0]     o_N_type_control_m3,
   output logic                  o_out_valid,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_cfg_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3*CTRL_W-1:0] IDLE_ROW = {3{IDLE_CODE}};

   state_t                              r_state;
   logic [DEPTH-1:0][3*CTRL_W-1:0]      r_table;
   logic [ADDR_W-1:0]                   r_row;
   logic [ITER_W-1:0]                   r_iter;
   logic [ADDR_W:0]                     r_num_rows;
   logic [ITER_W-1:0]                   r_num_iter;
   logic [3*CTRL_W-1:0]                 r_ctrl;
   logic                                r_out_valid;
   logic                                r_busy;
   logic                                r_done;
   logic                                r_cfg_err;

   state_t                              w_state_nx;
   logic [ADDR_W-1:0]                   w_row_nx;
   logic [ITER_W-1:0]                   w_iter_nx;
   logic [ADDR_W:0]                     w_num_rows_nx;
   logic [ITER_W-1:0]                   w_num_iter_nx;
   logic [3*CTRL_W-1:0]                 w_wr_data;
   logic                                w_wr_bad;
   logic                                w_hs;
   logic                                w_last_row;
   logic                                w_last_iter;

   // L, M, N, R, S (0..4) and the idle code are storable; 5 and 6 are not.
   function automatic logic code_ok(input logic [CTRL_W-1:0] c);
      return (c <= CTRL_W'(4)) || (c == IDLE_CODE);
   endfunction

   assign w_hs        = r_out_valid & i_out_ready;
   assign w_last_row  = ({1'b0, r_row} == (r_num_rows - (ADDR_W+1)'(1)));
   assign w_last_iter = (r_iter == (r_num_iter - ITER_W'(1)));

   // Replace illegal codes in an incoming row by IDLE_CODE and flag them.
   always_comb begin
      w_wr_data = '0;
      w_wr_bad  = 1'b0;
      for (int f = 0; f < 3; f++) begin
         if (code_ok(i_cfg_data[f*CTRL_W +: CTRL_W])) begin
            w_wr_data[f*CTRL_W +: CTRL_W] = i_cfg_data[f*CTRL_W +: CTRL_W];
         end else begin
            w_wr_data[f*CTRL_W +: CTRL_W] = IDLE_CODE;
            w_wr_bad                      = 1'b1;
         end
      end
   end

   // Next-state logic: row/iteration stepping, start, abort and completion.
   always_comb begin
      w_state_nx    = r_state;
      w_row_nx      = r_row;
      w_iter_nx     = r_iter;
      w_num_rows_nx = r_num_rows;
      w_num_iter_nx = r_num_iter;
      case (r_state)
         ST_IDLE: begin
            // start beats a simultaneous abort simply because abort is not looked at here
            if (i_start) begin
               w_num_rows_nx = i_num_rows;
               w_num_iter_nx = (i_num_iter == ITER_W'(0)) ? ITER_W'(1) : i_num_iter;
               w_row_nx      = ADDR_W'(0);
               w_iter_nx     = ITER_W'(0);
               if (i_num_rows == (ADDR_W+1)'(0)) begin
                  w_state_nx = ST_DONE;
               end else begin
                  w_state_nx = ST_RUN;
               end
            end else begin
               w_state_nx = ST_IDLE;
            end
         end
         ST_RUN: begin
            // abort has priority over a coinciding handshake
            if (i_abort) begin
               w_state_nx = ST_IDLE;
            end else if (w_hs) begin
               if (w_last_row) begin
                  w_row_nx = ADDR_W'(0);
                  if (w_last_iter) begin
                     w_state_nx = ST_DONE;
                  end else begin
                     w_iter_nx = r_iter + ITER_W'(1);
                  end
               end else begin
                  w_row_nx = r_row + ADDR_W'(1);
               end
            end else begin
               w_state_nx = ST_RUN;
            end
         end
         ST_DONE: begin
            w_state_nx = ST_IDLE;
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
   end

   // Schedule table and sticky configuration error flag.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_table   <= {DEPTH{IDLE_ROW}};
         r_cfg_err <= 1'b0;
      end else if (i_cfg_we) begin
         if (r_state == ST_IDLE) begin
            r_table[i_cfg_addr] <= w_wr_data;
            r_cfg_err           <= r_cfg_err | w_wr_bad;
         end else begin
            r_cfg_err <= 1'b1;
         end
      end else begin
         r_cfg_err <= r_cfg_err;
      end
   end

   // FSM state, counters and registered outputs derived from the next state.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_row       <= '0;
         r_iter      <= '0;
         r_num_rows  <= '0;
         r_num_iter  <= '0;
         r_ctrl      <= IDLE_ROW;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_row       <= w_row_nx;
         r_iter      <= w_iter_nx;
         r_num_rows  <= w_num_rows_nx;
         r_num_iter  <= w_num_iter_nx;
         r_ctrl      <= (w_state_nx == ST_RUN) ? r_table[w_row_nx] : IDLE_ROW;
         r_out_valid <= (w_state_nx == ST_RUN);
         r_busy      <= (w_state_nx != ST_IDLE);
         r_done      <= (w_state_nx == ST_DONE);
      end
   end

   assign o_N_type_control_m1 = r_ctrl[0*CTRL_W +: CTRL_W];
   assign o_N_type_control_m2 = r_ctrl[1*CTRL_W +: CTRL_W];
   assign o_N_type_control_m3 = r_ctrl[2*CTRL_W +: CTRL_W];
   assign o_out_valid         = r_out_valid;
   assign o_busy              = r_busy;
   assign o_done              = r_done;
   assign o_cfg_err           = r_cfg_err;

endmodule

// File: tb/tb_stage4_n_type_scheduler.sv
// Directed bench for stage4_n_type_scheduler. Expected rows are pushed to a
// scoreboard queue when a run is started and popped by a monitor on every
// accepted handshake.
module tb_stage4_n_type_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cfg_we;
   logic [3:0] cfg_addr;
   logic [8:0] cfg_data;
   logic       start;
   logic [4:0] num_rows;
   logic [4:0] num_iter;
   logic       abort;
   logic       out_ready;
   logic [2:0] m1, m2, m3;
   logic       out_valid, busy, done, cfg_err;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic       mon_en   = 1'b0;
   logic [8:0] exp_q[$];
   logic [8:0] tb_tab[16];

   stage4_n_type_scheduler dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr),
      .i_cfg_data(cfg_data), .i_start(start), .i_num_rows(num_rows),
      .i_num_iter(num_iter), .i_abort(abort), .i_out_ready(out_ready),
      .o_N_type_control_m1(m1), .o_N_type_control_m2(m2),
      .o_N_type_control_m3(m3), .o_out_valid(out_valid), .o_busy(busy),
      .o_done(done), .o_cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // bench's own view of what the table stores for a written row
   function automatic logic [8:0] clean(input logic [8:0] d);
      logic [8:0] r;
      logic [2:0] c;
      r = d;
      for (int f = 0; f < 3; f++) begin
         c = d[f*3 +: 3];
         if (c == 3'd5 || c == 3'd6) r[f*3 +: 3] = 3'd7;
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic prog(input int addr, input logic [8:0] data);
      cfg_we   = 1'b1;
      cfg_addr = 4'(addr);
      cfg_data = data;
      tick();
      cfg_we   = 1'b0;
      tb_tab[addr] = clean(data);
   endtask

   task automatic do_start(input int rows, input int iter, input bit push_all);
      int it;
      it = (iter == 0) ? 1 : iter;
      if (push_all) begin
         for (int i = 0; i < it; i++)
            for (int r = 0; r < rows; r++) exp_q.push_back(tb_tab[r]);
      end
      start    = 1'b1;
      num_rows = 5'(rows);
      num_iter = 5'(iter);
      tick();
      start    = 1'b0;
      chk("start_latency", out_valid, (rows != 0));
   endtask

   task automatic wait_done(input int exp_v);
      int n, v;
      n = 0;
      v = 0;
      while (!done && n < 300) begin
         if (out_valid) v++;
         tick();
         n++;
      end
      chk("done_seen", done, 1);
      chk("valid_cycles", v, exp_v);
      chk("run_cycles", n, exp_v);
      chk("done_valid_low", out_valid, 0);
      chk("done_busy", busy, 1);
      tick();
      chk("done_pulse_end", done, 0);
      chk("busy_fall", busy, 0);
      chk("ctrl_idle_after", {m3, m2, m1}, 9'h1FF);
   endtask

   task automatic chk_reset_state();
      chk("rst_ctrl", {m3, m2, m1}, 9'h1FF);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", cfg_err, 0);
   endtask

   // Scoreboard monitor: pop on every accepted row, check idle code otherwise.
   always @(negedge clk) begin
      if (mon_en) begin
         if (out_valid && out_ready) begin
            chk("sb_nonempty", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("row", {m3, m2, m1}, exp_q.pop_front());
         end else if (!out_valid) begin
            chk("idle_ctrl", {m3, m2, m1}, 9'h1FF);
         end
      end
   end

   initial begin
      rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0;
      num_rows = '0; num_iter = '0; abort = 1'b0; out_ready = 1'b1;
      for (int a = 0; a < 16; a++) tb_tab[a] = 9'h1FF;
      tick(); tick();
      rst_n = 1'b1;
      chk_reset_state();
      mon_en = 1'b1;

      // program and basic run: m1 = 2,0,1,2,0,1
      prog(0, {3'd0, 3'd1, 3'd2});
      prog(1, {3'd3, 3'd4, 3'd0});
      prog(2, {3'd1, 3'd1, 3'd1});
      chk("err_clean", cfg_err, 0);
      do_start(3, 2, 1'b1);
      chk("row0_m1", m1, 3'd2);
      wait_done(6);

      // backpressure on row 1
      do_start(3, 2, 1'b1);
      tick();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_m1", m1, 3'd0);
         chk("stall_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      wait_done(5);

      // write while busy is dropped and flagged
      do_start(3, 1, 1'b1);
      cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = {3'd4, 3'd4, 3'd4};
      tick();
      cfg_we = 1'b0;
      chk("busy_write_err", cfg_err, 1);
      wait_done(2);
      do_start(1, 1, 1'b1);
      wait_done(1);

      // reset clears table and flag; illegal code write
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk_reset_state();
      for (int a = 0; a < 16; a++) tb_tab[a] = 9'h1FF;
      prog(0, {3'd0, 3'd1, 3'd2});
      prog(1, {3'd3, 3'd4, 3'd0});
      prog(2, {3'd1, 3'd1, 3'd1});
      chk("err_before_illegal", cfg_err, 0);
      prog(4, {3'd0, 3'd5, 3'd3});
      chk("illegal_err", cfg_err, 1);
      do_start(5, 1, 1'b1);
      wait_done(5);

      // zero rows: done without any row
      start = 1'b1; num_rows = 5'd0; num_iter = 5'd3;
      tick();
      start = 1'b0;
      chk("zero_done", done, 1);
      chk("zero_valid", out_valid, 0);
      chk("zero_busy", busy, 1);
      tick();
      chk("zero_done_end", done, 0);
      chk("zero_busy_end", busy, 0);

      // num_iter = 0 behaves as one iteration
      do_start(1, 0, 1'b1);
      wait_done(1);

      // full depth, wraps 15 -> 0
      for (int a = 3; a < 16; a++)
         prog(a, {3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)), 3'($urandom_range(0, 4))});
      do_start(16, 2, 1'b1);
      wait_done(32);

      // abort on row 1 of iteration 0, then restart from row 0
      exp_q.push_back(tb_tab[0]);
      exp_q.push_back(tb_tab[1]);
      do_start(3, 2, 1'b0);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_ctrl", {m3, m2, m1}, 9'h1FF);
      tick();
      chk("abort_no_done", done, 0);
      do_start(3, 1, 1'b1);
      chk("restart_row0", {m3, m2, m1}, tb_tab[0]);
      wait_done(3);

      // reset mid-run, then run the cleared table
      exp_q.push_back(tb_tab[0]);
      exp_q.push_back(tb_tab[1]);
      do_start(3, 2, 1'b0);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk_reset_state();
      for (int a = 0; a < 16; a++) tb_tab[a] = 9'h1FF;
      do_start(3, 1, 1'b1);
      wait_done(3);

      chk("sb_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
